// File: rtl/fec23_pkg.sv
// Shared constants, stage-2 payload type and syndrome helpers for the
// shortened Hamming (15,10) decoder, g(D) = D^5 + D^4 + D^2 + 1.
package fec23_pkg;

  localparam int unsigned FEC23_N     = 15;
  localparam int unsigned FEC23_K     = 10;
  localparam int unsigned FEC23_P     = FEC23_N - FEC23_K;
  localparam int unsigned FEC23_CNT_W = 4;
  localparam int unsigned FEC23_ERR_W = 8;

  // g(D) without its D^5 term; applied when the syndrome MSB shifts out
  localparam logic [FEC23_P-1:0] FEC23_GPOLY = 5'b10101;

  // D^i mod g(D) for i = 0..14; index i is the codeword bit position
  localparam logic [FEC23_P-1:0] FEC23_SYND_TBL [FEC23_N] = '{
    5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000,
    5'b10101, 5'b11111, 5'b01011, 5'b10110, 5'b11001,
    5'b00111, 5'b01110, 5'b11100, 5'b01101, 5'b11010
  };

  // Completed word handed from the receive stage to the correction stage.
  // Parity bits are not kept: the syndrome already carries their information.
  typedef struct packed {
    logic [FEC23_K-1:0] info;
    logic [FEC23_P-1:0] synd;
  } fec23_s2_t;

  // One serial step of the remainder division, MSB-first input
  function automatic logic [FEC23_P-1:0] fec23_synd_step(
    input logic [FEC23_P-1:0] s,
    input logic               din
  );
    return {s[FEC23_P-2:0], din} ^ (s[FEC23_P-1] ? FEC23_GPOLY : '0);
  endfunction

endpackage

// File: rtl/fec23_synd_lut.sv
// Syndrome decoder: maps a 5-bit syndrome to a one-hot error mask over the
// 15 codeword bits, or flags the syndrome as uncorrectable.
//   i_synd        syndrome of the received word
//   o_err_mask_c  one-hot bit to invert (all zero for syndrome 0 or uncorrectable)
//   o_uncorr_c    nonzero syndrome with no single-bit explanation
module fec23_synd_lut
  import fec23_pkg::*;
(
  input  logic [4:0]  i_synd,
  output logic [14:0] o_err_mask_c,
  output logic        o_uncorr_c
);

  logic [14:0] w_mask;

  // Table has no zero entry, so syndrome 0 naturally yields an empty mask
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < FEC23_N; i++) begin
      if (i_synd == FEC23_SYND_TBL[i]) begin
        w_mask[i] = 1'b1;
      end
    end
  end

  assign o_err_mask_c = w_mask;
  assign o_uncorr_c   = (i_synd != '0) && (w_mask == '0);

endmodule

// File: rtl/fec23_dec.sv
// Serial 2/3-rate FEC decoder for a shortened Hamming (15,10) code.
//   clk_6M        baseband clock
//   rstz          synchronous active-low reset
//   loadini_p     start-of-payload pulse; clears bit counter, syndrome, err_cnt
//   decode_en     enables acceptance of datvalid_p-qualified bits
//   datvalid_p    qualifies fec23_datin
//   fec23_datin   serial bit, first bit is coefficient D^14
//   dec_data      corrected information bits, bit 9 = first received bit
//   dec_valid_p   one-cycle pulse marking dec_data and flags valid
//   dec_corrected single-bit error corrected in last emitted word
//   dec_uncorr    uncorrectable error in last emitted word
//   err_cnt       saturating count of uncorrectable words
module fec23_dec
  import fec23_pkg::*;
(
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       loadini_p,
  input  logic       decode_en,
  input  logic       datvalid_p,
  input  logic       fec23_datin,
  output logic [9:0] dec_data,
  output logic       dec_valid_p,
  output logic       dec_corrected,
  output logic       dec_uncorr,
  output logic [7:0] err_cnt
);

  logic [FEC23_CNT_W-1:0] r_bit_cnt;
  logic [FEC23_N-2:0]     r_buf;       // first 14 bits; the 15th is parity and arrives live
  logic [FEC23_P-1:0]     r_synd;
  fec23_s2_t              r_s2;
  logic                   r_s2_vld;

  logic                   w_accept;
  logic                   w_last;
  logic [FEC23_P-1:0]     w_synd_next;
  logic [14:0]            w_mask;
  logic                   w_uncorr;
  logic [FEC23_K-1:0]     w_data_fix;

  assign w_accept    = decode_en & datvalid_p & ~loadini_p;
  assign w_last      = w_accept && (r_bit_cnt == FEC23_CNT_W'(FEC23_N - 1));
  assign w_synd_next = fec23_synd_step(r_synd, fec23_datin);

  fec23_synd_lut u_lut (
    .i_synd       (r_s2.synd),
    .o_err_mask_c (w_mask),
    .o_uncorr_c   (w_uncorr)
  );

  // Only information-bit positions of the mask matter for the output data
  assign w_data_fix = r_s2.info ^ w_mask[14:5];

  // Receive stage: bit counter, shift buffer, running syndrome, stage-2 capture
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      r_bit_cnt <= '0;
      r_buf     <= '0;
      r_synd    <= '0;
      r_s2      <= '0;
      r_s2_vld  <= 1'b0;
    end else begin
      if (loadini_p) begin
        r_bit_cnt <= '0;
        r_synd    <= '0;
      end else if (w_accept) begin
        r_buf <= {r_buf[FEC23_N-3:0], fec23_datin};
        if (w_last) begin
          r_bit_cnt <= '0;
          r_synd    <= '0;
          r_s2      <= '{info: r_buf[FEC23_N-2:FEC23_P-1], synd: w_synd_next};
        end else begin
          r_bit_cnt <= r_bit_cnt + FEC23_CNT_W'(1);
          r_synd    <= w_synd_next;
        end
      end
      // Stage 2 is consumed on the very next edge, so a new capture (15 bits
      // later at the earliest) can never overwrite an unconsumed word.
      r_s2_vld <= w_last;
    end
  end

  // Correction stage: registered outputs, held between pulses
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      dec_data      <= '0;
      dec_valid_p   <= 1'b0;
      dec_corrected <= 1'b0;
      dec_uncorr    <= 1'b0;
      err_cnt       <= '0;
    end else begin
      dec_valid_p <= r_s2_vld;
      if (r_s2_vld) begin
        dec_data      <= w_data_fix;
        dec_corrected <= |w_mask;
        dec_uncorr    <= w_uncorr;
      end
      // loadini_p clears the count and swallows a coincident increment
      if (loadini_p) begin
        err_cnt <= '0;
      end else if (r_s2_vld && w_uncorr && (err_cnt != '1)) begin
        err_cnt <= err_cnt + FEC23_ERR_W'(1);
      end
    end
  end

endmodule
